// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM command engine between the ROM loader byte stream and core ports A/B.
// Loader bytes queue in a small FIFO; one transaction is in flight at a time.
module sdram_port_arbiter #(
    parameter int ADDR_W         = 25,
    parameter int ROM_FIFO_DEPTH = 4,
    parameter int ROM_BURST_MAX  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rom_wr,
    input  logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              rom_full,
    output logic              rom_empty,
    output logic              rom_ovf,
    input  logic              a_rd,
    input  logic              a_wr,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [15:0]       a_din,
    output logic [15:0]       a_dout,
    output logic              a_ready,
    input  logic              b_rd,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [15:0]       b_dout,
    output logic              b_ready,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_we,
    output logic [ADDR_W-2:0] cmd_addr,
    output logic [15:0]       cmd_wdata,
    output logic [1:0]        cmd_be,
    input  logic              rsp_valid,
    input  logic [15:0]       rsp_data
);
    localparam int PW = $clog2(ROM_FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(ROM_BURST_MAX + 1);
    localparam logic [CW-1:0] DEPTH_C     = CW'(ROM_FIFO_DEPTH);
    localparam logic [BW-1:0] BURST_MAX_C = BW'(ROM_BURST_MAX);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DONE} state_t;
    typedef enum logic [1:0] {SRC_ROM, SRC_A, SRC_B} src_t;

    state_t state, next_state;
    src_t   src;

    logic [ADDR_W-1:0] f_addr [ROM_FIFO_DEPTH];
    logic [7:0]        f_data [ROM_FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              fifo_push, fifo_pop;

    logic [BW-1:0] burst_cnt;
    logic          rr_b;
    logic          grant_rom, grant_a, grant_b;
    logic          a_req, ab_pend, rom_pend, force_ab, pick_a;
    logic [ADDR_W-1:0] head_addr;
    logic [7:0]        head_data;

    // Word addressing drops the byte lane select of the core ports.
    logic unused_addr_lsb;
    assign unused_addr_lsb = a_addr[0] ^ b_addr[0];

    assign head_addr = f_addr[rd_ptr];
    assign head_data = f_data[rd_ptr];
    assign rom_full  = (count == DEPTH_C);
    assign rom_empty = (count == '0) && !(state != IDLE && src == SRC_ROM);
    // A full FIFO still accepts a byte in the same cycle its head is retired.
    assign fifo_push = rom_wr && (!rom_full || fifo_pop);

    assign a_req    = a_rd | a_wr;
    assign ab_pend  = a_req | b_rd;
    assign rom_pend = (count != '0);
    assign force_ab = (burst_cnt == BURST_MAX_C) && ab_pend;
    assign pick_a   = a_req && (!rr_b || !b_rd);

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            f_addr[wr_ptr] <= rom_addr;
            f_data[wr_ptr] <= rom_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rom_ovf <= 1'b0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(fifo_push) - CW'(fifo_pop);
            if (rom_wr && rom_full && !fifo_pop) rom_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        grant_rom  = 1'b0;
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        cmd_valid  = 1'b0;
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        fifo_pop   = 1'b0;
        case (state)
            IDLE: begin
                if (rom_pend && !force_ab) begin
                    grant_rom  = 1'b1;
                    next_state = ISSUE;
                end else if (ab_pend) begin
                    grant_a    = pick_a;
                    grant_b    = !pick_a;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                cmd_valid = 1'b1;
                if (cmd_ready) next_state = cmd_we ? DONE : WAIT_RSP;
            end
            WAIT_RSP: if (rsp_valid) next_state = DONE;
            DONE: begin
                a_ready    = (src == SRC_A);
                b_ready    = (src == SRC_B);
                fifo_pop   = (src == SRC_ROM);
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Command fields are latched at grant so they stay stable through ISSUE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src       <= SRC_ROM;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cmd_be    <= '0;
            rr_b      <= 1'b0;
            burst_cnt <= '0;
            a_dout    <= '0;
            b_dout    <= '0;
        end else begin
            if (grant_rom) begin
                src       <= SRC_ROM;
                cmd_we    <= 1'b1;
                cmd_addr  <= head_addr[ADDR_W-1:1];
                cmd_wdata <= {head_data, head_data};
                cmd_be    <= head_addr[0] ? 2'b10 : 2'b01;
                if (burst_cnt != BURST_MAX_C) burst_cnt <= burst_cnt + 1'b1;
            end else if (grant_a) begin
                src       <= SRC_A;
                cmd_we    <= a_wr;
                cmd_addr  <= a_addr[ADDR_W-1:1];
                cmd_wdata <= a_din;
                cmd_be    <= 2'b11;
                rr_b      <= 1'b1;
                burst_cnt <= '0;
            end else if (grant_b) begin
                src       <= SRC_B;
                cmd_we    <= 1'b0;
                cmd_addr  <= b_addr[ADDR_W-1:1];
                cmd_wdata <= '0;
                cmd_be    <= 2'b11;
                rr_b      <= 1'b0;
                burst_cnt <= '0;
            end else if (state == IDLE && !rom_pend) begin
                burst_cnt <= '0;
            end
            if (state == WAIT_RSP && rsp_valid) begin
                if (src == SRC_A) a_dout <= rsp_data;
                if (src == SRC_B) b_dout <= rsp_data;
            end
        end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: loader writes, A/B reads and writes,
// round-robin, ROM burst limit, FIFO overflow and mid-transaction reset.
module tb_sdram_port_arbiter;
    localparam int AW = 25;

    logic          clk = 1'b0;
    logic          reset;
    logic          rom_wr;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data;
    logic          rom_full, rom_empty, rom_ovf;
    logic          a_rd, a_wr;
    logic [AW-1:0] a_addr;
    logic [15:0]   a_din, a_dout;
    logic          a_ready;
    logic          b_rd;
    logic [AW-1:0] b_addr;
    logic [15:0]   b_dout;
    logic          b_ready;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-2:0] cmd_addr;
    logic [15:0]   cmd_wdata;
    logic [1:0]    cmd_be;
    logic          rsp_valid;
    logic [15:0]   rsp_data;

    sdram_port_arbiter #(.ADDR_W(AW), .ROM_FIFO_DEPTH(4), .ROM_BURST_MAX(16)) dut (
        .clk(clk), .reset(reset),
        .rom_wr(rom_wr), .rom_addr(rom_addr), .rom_data(rom_data),
        .rom_full(rom_full), .rom_empty(rom_empty), .rom_ovf(rom_ovf),
        .a_rd(a_rd), .a_wr(a_wr), .a_addr(a_addr), .a_din(a_din),
        .a_dout(a_dout), .a_ready(a_ready),
        .b_rd(b_rd), .b_addr(b_addr), .b_dout(b_dout), .b_ready(b_ready),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [AW-2:0] q_addr[$];
    logic          q_we[$];
    logic [1:0]    q_be[$];
    logic [15:0]   q_wd[$];
    int            a_cnt = 0;
    int            b_cnt = 0;
    int            rsp_lat = 2;
    int            rsp_dly = 0;
    logic [15:0]   rsp_val = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        q_addr.delete(); q_we.delete(); q_be.delete(); q_wd.delete();
    endtask

    // SDRAM engine model: logs accepted commands, answers reads rsp_lat cycles later.
    initial begin
        rsp_valid = 1'b0;
        rsp_data  = '0;
        forever begin
            @(negedge clk);
            rsp_valid = 1'b0;
            if (rsp_dly > 0) begin
                rsp_dly--;
                if (rsp_dly == 0) begin
                    rsp_valid = 1'b1;
                    rsp_data  = rsp_val;
                end
            end
            if (cmd_valid && cmd_ready) begin
                q_addr.push_back(cmd_addr);
                q_we.push_back(cmd_we);
                q_be.push_back(cmd_be);
                q_wd.push_back(cmd_wdata);
                if (!cmd_we) rsp_dly = rsp_lat;
            end
            if (a_ready) a_cnt++;
            if (b_ready) b_cnt++;
        end
    end

    initial begin
        int lat, n, a0, b0, na, nb, alt_err, nrom;
        reset = 1'b1; rom_wr = 1'b0; rom_addr = '0; rom_data = '0;
        a_rd = 1'b0; a_wr = 1'b0; a_addr = '0; a_din = '0;
        b_rd = 1'b0; b_addr = '0; cmd_ready = 1'b0;
        repeat (3) tick();
        check("rst_rom_empty", rom_empty, 1);
        check("rst_rom_full", rom_full, 0);
        check("rst_rom_ovf", rom_ovf, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_a_dout", a_dout, 0);
        reset = 1'b0; cmd_ready = 1'b1;
        tick();

        // Loader bytes 11,22,33,44 at addresses 0..3
        for (int i = 0; i < 4; i++) begin
            rom_wr = 1'b1; rom_addr = AW'(i); rom_data = 8'((i + 1) * 17);
            tick();
        end
        rom_wr = 1'b0;
        repeat (20) tick();
        check("t1_ncmd", q_addr.size(), 4);
        for (int i = 0; i < 4 && i < q_addr.size(); i++) begin
            check("t1_addr", q_addr[i], i / 2);
            check("t1_we", q_we[i], 1);
            check("t1_be", q_be[i], (i % 2 == 1) ? 2 : 1);
            check("t1_wdata", q_wd[i], 32'(16'h1111 * (i + 1)));
        end
        check("t1_rom_empty", rom_empty, 1);

        // Port A read; pulse lands 4 edges after the request cycle (the 5th cycle)
        clr(); a0 = a_cnt;
        rsp_val = 16'hBEEF; a_addr = 25'h100; a_rd = 1'b1;
        lat = 0;
        do begin tick(); lat++; end while (!a_ready && lat < 30);
        a_rd = 1'b0;
        check("t2_rd_ready", a_ready, 1);
        check("t2_rd_latency", lat, 4);
        check("t2_rd_dout", a_dout, 16'hBEEF);
        tick();
        check("t2_rd_pulse_width", a_ready, 0);
        repeat (4) tick();
        check("t2_rd_count", a_cnt - a0, 1);
        check("t2_rd_ncmd", q_addr.size(), 1);
        if (q_addr.size() > 0) begin
            check("t2_rd_addr", q_addr[0], 32'h80);
            check("t2_rd_we", q_we[0], 0);
        end

        // Port A write with a_rd also set: write wins; pulse 2 edges after request
        clr();
        a_addr = 25'h101; a_din = 16'h1234; a_wr = 1'b1; a_rd = 1'b1;
        lat = 0;
        do begin tick(); lat++; end while (!a_ready && lat < 30);
        a_wr = 1'b0; a_rd = 1'b0;
        check("t2_wr_ready", a_ready, 1);
        check("t2_wr_latency", lat, 2);
        repeat (4) tick();
        check("t2_wr_ncmd", q_addr.size(), 1);
        if (q_addr.size() > 0) begin
            check("t2_wr_addr", q_addr[0], 32'h80);
            check("t2_wr_we", q_we[0], 1);
            check("t2_wr_be", q_be[0], 3);
            check("t2_wr_wdata", q_wd[0], 16'h1234);
        end

        // A and B held together: grants alternate, starting with B (A went last)
        clr(); a0 = a_cnt; b0 = b_cnt;
        a_addr = 25'h200; b_addr = 25'h400; a_rd = 1'b1; b_rd = 1'b1;
        repeat (40) tick();
        a_rd = 1'b0; b_rd = 1'b0;
        repeat (10) tick();
        n = q_addr.size(); na = 0; nb = 0; alt_err = 0;
        for (int i = 0; i < n; i++) begin
            if (q_addr[i] == 24'h100) na++;
            else if (q_addr[i] == 24'h200) nb++;
            else alt_err++;
            if (i > 0 && q_addr[i] == q_addr[i-1]) alt_err++;
        end
        check("t3_enough_grants", n >= 6, 1);
        check("t3_first_is_b", (n > 0) ? q_addr[0] : 0, 32'h200);
        check("t3_alternation", alt_err, 0);
        check("t3_a_pulses", a_cnt - a0, na);
        check("t3_b_pulses", b_cnt - b0, nb);

        // Overflow: engine stalled, 5th byte dropped
        clr(); cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rom_wr = 1'b1; rom_addr = AW'(32'h10 + i); rom_data = 8'(8'hA0 + i);
            tick();
        end
        rom_wr = 1'b0;
        check("t5_full", rom_full, 1);
        check("t5_ovf", rom_ovf, 1);
        check("t5_not_empty", rom_empty, 0);
        cmd_ready = 1'b1;
        repeat (20) tick();
        check("t5_ncmd", q_addr.size(), 4);
        for (int i = 0; i < 4 && i < q_addr.size(); i++) begin
            check("t5_addr", q_addr[i], (32'h10 + i) >> 1);
            check("t5_wdata", q_wd[i], {2{8'(8'hA0 + i)}});
            check("t5_be", q_be[i], (i % 2 == 1) ? 2 : 1);
        end
        check("t5_empty_after", rom_empty, 1);
        check("t5_ovf_sticky", rom_ovf, 1);

        // Burst limit: FIFO kept full, B gets in after exactly 16 ROM writes
        clr(); cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rom_wr = 1'b1; rom_addr = AW'(32'h20 + i); rom_data = 8'(i);
            tick();
        end
        rom_wr = 1'b0;
        check("t4_full", rom_full, 1);
        b_addr = 25'h400; b_rd = 1'b1; cmd_ready = 1'b1; rsp_val = 16'hC0DE;
        n = 0;
        do begin
            rom_wr = !rom_full; rom_addr = AW'(32'h40 + n); rom_data = 8'(n);
            tick(); n++;
        end while (!b_ready && n < 300);
        rom_wr = 1'b0; b_rd = 1'b0;
        check("t4_b_ready", b_ready, 1);
        check("t4_b_dout", b_dout, 16'hC0DE);
        nrom = 0;
        for (int i = 0; i < q_we.size() && q_we[i]; i++) nrom++;
        check("t4_rom_before_b", nrom, 16);
        repeat (60) tick();
        check("t4_drained", rom_empty, 1);

        // Reset during WAIT_RSP: transaction abandoned, late response ignored
        clr(); a0 = a_cnt; b0 = b_cnt;
        rsp_val = 16'h5555; rsp_lat = 6; a_addr = 25'h100; a_rd = 1'b1;
        tick();
        rom_wr = 1'b1; rom_addr = '0; rom_data = 8'h77;
        tick();
        rom_wr = 1'b0;
        tick();
        check("t6_fifo_loaded", rom_empty, 0);
        reset = 1'b1; a_rd = 1'b0;
        tick();
        check("t6_cmd_valid", cmd_valid, 0);
        check("t6_rom_empty", rom_empty, 1);
        check("t6_rom_full", rom_full, 0);
        check("t6_rom_ovf", rom_ovf, 0);
        check("t6_a_dout", a_dout, 0);
        check("t6_b_dout", b_dout, 0);
        reset = 1'b0;
        repeat (10) tick();
        check("t6_no_a_ready", a_cnt - a0, 0);
        check("t6_no_b_ready", b_cnt - b0, 0);
        check("t6_ncmd", q_addr.size(), 1);
        check("t6_still_empty", rom_empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
